// File: rtl/ff_pkg.sv
// Shared helpers and constants for the windowed find-first pipeline.
package ff_pkg;

    // Smallest k such that base**k >= val (integer logarithm, rounded up).
    function automatic int clog(input int val, input int base);
        int k;
        int p;
        k = 0;
        p = 1;
        for (int i = 0; i < 32; i++) begin
            if (p < val) begin
                p = p * base;
                k = k + 1;
            end
        end
        return k;
    endfunction

    // base**val for small non-negative exponents.
    function automatic int pow(input int base, input int val);
        int r;
        r = 1;
        for (int i = 0; i < val; i++) begin
            r = r * base;
        end
        return r;
    endfunction

    // Offset of tree level lvl in a flat node array: leaves (level 0) first,
    // then each coarser level packed right after the previous one.
    function automatic int lvl_off(input int lvl, input int vw, input int bw);
        int o;
        int c;
        o = 0;
        c = vw;
        for (int j = 0; j < lvl; j++) begin
            o = o + c;
            c = c / bw;
        end
        return o;
    endfunction

    // Search mode encoding on req_mode.
    localparam logic FF_MODE_SET = 1'b0;
    localparam logic FF_MODE_CLR = 1'b1;

    // Tree shape for the default configuration (64-bit bitmap, fan-in 2,
    // two levels per pipeline slice).
    localparam int BLOCK_DEPTH = clog(64, 2);
    localparam int NSTG        = (BLOCK_DEPTH + 2 - 1) / 2;

endpackage

// File: rtl/ff_wnd_node.sv
// One combinational tree node: OR of child valids plus index of the
// lowest-numbered valid child, expressed in absolute (rotated) offset units.
module ff_wnd_node
    import ff_pkg::*;
#(
    parameter int BLOCK_WIDTH = 2,
    parameter int IND_WIDTH   = 6,
    parameter int LVL         = 0   // level of the children (0 = leaf bits)
) (
    input  logic [BLOCK_WIDTH-1:0]           i_val,
    input  logic [BLOCK_WIDTH*IND_WIDTH-1:0] i_ind,
    output logic                             o_val,
    output logic [IND_WIDTH-1:0]             o_ind
);

    // Each child covers SPAN consecutive offsets.
    localparam int SPAN = pow(BLOCK_WIDTH, LVL);

    // Priority select: scan from the top child down so the lowest valid child wins.
    always_comb begin
        o_val = |i_val;
        o_ind = '0;
        for (int c = BLOCK_WIDTH - 1; c >= 0; c--) begin
            if (i_val[c]) begin
                o_ind = IND_WIDTH'(c * SPAN) + i_ind[c*IND_WIDTH +: IND_WIDTH];
            end
        end
    end

endmodule

// File: rtl/ff_wnd_pipe.sv
// Pipelined find-first-set/clear over a circular window of a bitmap.
// Stage 0 rotates/inverts/masks, a registered tree finds the lowest offset,
// and the output stage converts the offset back to an absolute index.
module ff_wnd_pipe
    import ff_pkg::*;
#(
    parameter int VECT_WIDTH     = 64,
    parameter int VECT_IND_WIDTH = 6,
    parameter int BLOCK_WIDTH    = 2,
    parameter int LVLS_PER_STAGE = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_val,
    output logic                      req_rdy,
    input  logic [VECT_WIDTH-1:0]     req_vect,
    input  logic [VECT_IND_WIDTH-1:0] req_head,
    input  logic [VECT_IND_WIDTH:0]   req_len,
    input  logic                      req_mode,
    output logic                      rsp_val,
    input  logic                      rsp_rdy,
    output logic                      rsp_found,
    output logic [VECT_IND_WIDTH-1:0] rsp_ind
);

    localparam int L_DEPTH = clog(VECT_WIDTH, BLOCK_WIDTH);
    localparam int L_NSTG  = (L_DEPTH + LVLS_PER_STAGE - 1) / LVLS_PER_STAGE;
    localparam int L_TOTAL = lvl_off(L_DEPTH + 1, VECT_WIDTH, BLOCK_WIDTH);
    localparam int L_ROOT  = lvl_off(L_DEPTH, VECT_WIDTH, BLOCK_WIDTH);
    localparam logic [VECT_IND_WIDTH:0] L_VW = (VECT_IND_WIDTH+1)'(VECT_WIDTH);

    logic                      w_adv;
    logic [VECT_WIDTH-1:0]     w_s0_vect;
    logic [VECT_IND_WIDTH:0]   w_len;

    logic                      r_stg_val [0:L_NSTG];
    logic [VECT_IND_WIDTH-1:0] r_head    [0:L_NSTG];
    logic [VECT_WIDTH-1:0]     r_s0_vect;
    logic                      r_rsp_val;
    logic                      r_rsp_found;
    logic [VECT_IND_WIDTH-1:0] r_rsp_ind;

    // Flat node arrays over all levels: pre = node output, post = after the
    // optional pipeline register (what the next level consumes).
    logic                      w_pre_val [L_TOTAL];
    logic [VECT_IND_WIDTH-1:0] w_pre_ind [L_TOTAL];
    logic                      w_val     [L_TOTAL];
    logic [VECT_IND_WIDTH-1:0] w_ind     [L_TOTAL];

    // Global stall: everything moves only when the output slot is free or draining.
    assign w_adv   = !r_rsp_val || rsp_rdy;
    assign req_rdy = w_adv;

    // Rotate so head lands at offset 0, invert for find-clear, drop bits past len.
    always_comb begin
        w_len     = (req_len > L_VW) ? L_VW : req_len;
        w_s0_vect = '0;
        for (int i = 0; i < VECT_WIDTH; i++) begin
            w_s0_vect[i] = req_vect[(i + int'(req_head)) % VECT_WIDTH] ^ (req_mode == FF_MODE_CLR);
            if (i >= int'(w_len)) begin
                w_s0_vect[i] = 1'b0;
            end
        end
    end

    // Stage-0 register, valid/head carry chain and output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s <= L_NSTG; s++) begin
                r_stg_val[s] <= 1'b0;
                r_head[s]    <= '0;
            end
            r_s0_vect   <= '0;
            r_rsp_val   <= 1'b0;
            r_rsp_found <= 1'b0;
            r_rsp_ind   <= '0;
        end else if (w_adv) begin
            r_stg_val[0] <= req_val;
            r_head[0]    <= req_head;
            r_s0_vect    <= w_s0_vect;
            for (int s = 1; s <= L_NSTG; s++) begin
                r_stg_val[s] <= r_stg_val[s-1];
                r_head[s]    <= r_head[s-1];
            end
            r_rsp_val   <= r_stg_val[L_NSTG];
            r_rsp_found <= r_stg_val[L_NSTG] && w_val[L_ROOT];
            // Offset back to absolute index; the narrow add wraps naturally.
            r_rsp_ind   <= (r_stg_val[L_NSTG] && w_val[L_ROOT]) ?
                           (w_ind[L_ROOT] + r_head[L_NSTG]) : '0;
        end
    end

    assign rsp_val   = r_rsp_val;
    assign rsp_found = r_rsp_found;
    assign rsp_ind   = r_rsp_ind;

    // Tree: level 0 is the masked rotated vector, level L_DEPTH is the root.
    for (genvar gi = 0; gi <= L_DEPTH; gi++) begin : g_lvl
        localparam int OFF = lvl_off(gi, VECT_WIDTH, BLOCK_WIDTH);
        localparam int CNT = VECT_WIDTH / pow(BLOCK_WIDTH, gi);
        localparam bit REG = (gi > 0) && (((gi % LVLS_PER_STAGE) == 0) || (gi == L_DEPTH));

        if (gi == 0) begin : g_leaf
            for (genvar gn = 0; gn < CNT; gn++) begin : g_bit
                assign w_pre_val[OFF+gn] = r_s0_vect[gn];
                assign w_pre_ind[OFF+gn] = '0;
            end
        end else begin : g_nodes
            localparam int POFF = lvl_off(gi - 1, VECT_WIDTH, BLOCK_WIDTH);
            for (genvar gn = 0; gn < CNT; gn++) begin : g_node
                logic [BLOCK_WIDTH-1:0]                w_nval;
                logic [BLOCK_WIDTH*VECT_IND_WIDTH-1:0] w_nind;
                for (genvar gc = 0; gc < BLOCK_WIDTH; gc++) begin : g_child
                    assign w_nval[gc] = w_val[POFF + gn*BLOCK_WIDTH + gc];
                    assign w_nind[gc*VECT_IND_WIDTH +: VECT_IND_WIDTH] = w_ind[POFF + gn*BLOCK_WIDTH + gc];
                end
                ff_wnd_node #(
                    .BLOCK_WIDTH (BLOCK_WIDTH),
                    .IND_WIDTH   (VECT_IND_WIDTH),
                    .LVL         (gi - 1)
                ) u_node (
                    .i_val (w_nval),
                    .i_ind (w_nind),
                    .o_val (w_pre_val[OFF+gn]),
                    .o_ind (w_pre_ind[OFF+gn])
                );
            end
        end

        if (REG) begin : g_reg
            logic                      r_val [CNT];
            logic [VECT_IND_WIDTH-1:0] r_ind [CNT];
            // Pipeline slice after this level, stalled together with the rest.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int n = 0; n < CNT; n++) begin
                        r_val[n] <= 1'b0;
                        r_ind[n] <= '0;
                    end
                end else if (w_adv) begin
                    for (int n = 0; n < CNT; n++) begin
                        r_val[n] <= w_pre_val[OFF+n];
                        r_ind[n] <= w_pre_ind[OFF+n];
                    end
                end
            end
            for (genvar gn = 0; gn < CNT; gn++) begin : g_out
                assign w_val[OFF+gn] = r_val[gn];
                assign w_ind[OFF+gn] = r_ind[gn];
            end
        end else begin : g_wire
            for (genvar gn = 0; gn < CNT; gn++) begin : g_out
                assign w_val[OFF+gn] = w_pre_val[OFF+gn];
                assign w_ind[OFF+gn] = w_pre_ind[OFF+gn];
            end
        end
    end

endmodule
